// File: rtl/rule90_seed_loader_pkg.sv
// Shared types and default geometry for the Rule 90 seed loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rule90_pkg;

    localparam int CELLS  = 512;
    localparam int WORD_W = 32;
    localparam int WORDS  = CELLS / WORD_W;
    localparam int IDX_W  = $clog2(WORDS);

    typedef enum logic {S_FILL, S_LOAD} loader_state_t;

    typedef logic [CELLS-1:0] cells_t;

endpackage

// File: rtl/rule90_seed_loader_if.sv
// Narrow seed-word stream into the loader (valid/ready, one word per handshake).
// Latency: n/a (wires only).
// Backpressure: the slave deasserts in_ready; the master holds its word until accepted.
//
// Signals:
//   in_valid  master->slave  word available
//   in_data   master->slave  seed word, word k of a frame lands on cells [k*WORD_W +: WORD_W]
//   in_last   master->slave  final word of a frame
//   in_ready  slave->master  word accepted on a posedge where in_valid && in_ready
interface rule90_seed_loader_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/rule90_seed_loader_gen_counter.sv
// Saturating generation counter with synchronous clear.
// Latency: count reflects clear/increment one cycle after the posedge that samples it.
// Backpressure: none; increments every cycle not cleared, sticks at all-ones.
//
// Ports: clk, reset (sync, active-high), clear (sync), count (GEN_W).
module rule90_gen_counter #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [GEN_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rule90_seed_loader.sv
// Assembles a CELLS-wide seed from a word stream and presents it to the automaton as load/data.
// Latency: load rises the cycle after the final word's handshake and stays high LOAD_HOLD cycles.
// Backpressure: in_ready is low for the whole LOAD phase (and in reset); no path from in_valid.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   s (slave)       in_valid/in_data/in_last/in_ready word stream
//   load, data      automaton overwrite strobe and committed seed
//   busy            high while in LOAD
//   err_short       one-cycle pulse when a frame ends early and is dropped
//   gen_count       generations since load fell, saturating
module rule90_seed_loader #(
    parameter int WORD_W    = 32,
    parameter int CELLS     = 512,
    parameter int LOAD_HOLD = 1,
    parameter int GEN_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    rule90_seed_loader_if.slave s,
    output logic                load,
    output logic [CELLS-1:0]    data,
    output logic                busy,
    output logic                err_short,
    output logic [GEN_W-1:0]    gen_count
);
    import rule90_pkg::*;

    localparam int FRAME_WORDS = CELLS / WORD_W;
    localparam int FIDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int HOLD_W      = 3;

    loader_state_t      state;
    logic [FIDX_W-1:0]  idx;
    logic [CELLS-1:0]   staging;
    logic [CELLS-1:0]   staging_wr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               in_ready_q;

    logic accept;
    logic last_word;
    logic commit;
    logic gen_clear;

    assign s.in_ready = in_ready_q;
    assign accept     = s.in_valid && in_ready_q;
    assign last_word  = (idx == FIDX_W'(FRAME_WORDS - 1));
    assign commit     = (state == S_FILL) && accept && last_word;

    // Clearing on the commit edge as well as while load is high keeps gen_count
    // at zero for every load-high cycle and for the first cycle after load falls.
    assign gen_clear  = commit || load;

    // Staging with the current word merged in; used both for the running
    // write and for the full-frame commit so the last word reaches data directly.
    always_comb begin
        staging_wr = staging;
        staging_wr[idx*WORD_W +: WORD_W] = s.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FILL;
            idx        <= '0;
            staging    <= '0;
            hold_cnt   <= '0;
            in_ready_q <= 1'b0;
            load       <= 1'b0;
            busy       <= 1'b0;
            err_short  <= 1'b0;
            data       <= '0;
        end else begin
            err_short <= 1'b0;
            case (state)
                S_FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (last_word) begin
                            // in_last is deliberately ignored on the final word.
                            staging    <= staging_wr;
                            data       <= staging_wr;
                            idx        <= '0;
                            state      <= S_LOAD;
                            load       <= 1'b1;
                            busy       <= 1'b1;
                            in_ready_q <= 1'b0;
                            hold_cnt   <= HOLD_W'(LOAD_HOLD - 1);
                        end else if (s.in_last) begin
                            // Early end: drop the frame, leave data/load alone.
                            idx       <= '0;
                            err_short <= 1'b1;
                        end else begin
                            staging <= staging_wr;
                            idx     <= idx + 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (hold_cnt == '0) begin
                        state      <= S_FILL;
                        load       <= 1'b0;
                        busy       <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    rule90_gen_counter #(
        .GEN_W (GEN_W)
    ) u_gen_counter (
        .clk   (clk),
        .reset (reset),
        .clear (gen_clear),
        .count (gen_count)
    );

endmodule

// File: tb/tb_rule90_seed_loader.sv
// Scoreboard bench for rule90_seed_loader: two instances (default, and LOAD_HOLD=3/GEN_W=4)
// share one word driver; expected load/err events are queued at issue time and popped by a
// negedge monitor whenever a DUT raises load or err_short.
`timescale 1ns/1ps
module tb_rule90_seed_loader;
    import rule90_pkg::*;

    localparam int HOLD_B = 3;
    localparam int GEN_B  = 4;

    typedef struct {
        bit     is_err;
        cells_t dat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        drv_valid = 1'b0;
    logic [31:0] drv_data  = '0;
    logic        drv_last  = 1'b0;
    bit          sel       = 1'b0;

    rule90_seed_loader_if #(.WORD_W(WORD_W)) ifa ();
    rule90_seed_loader_if #(.WORD_W(WORD_W)) ifb ();

    assign ifa.in_valid = drv_valid && !sel;
    assign ifa.in_data  = drv_data;
    assign ifa.in_last  = drv_last;
    assign ifb.in_valid = drv_valid && sel;
    assign ifb.in_data  = drv_data;
    assign ifb.in_last  = drv_last;

    logic             load_a, busy_a, err_a;
    cells_t           data_a;
    logic [15:0]      gen_a;
    logic             load_b, busy_b, err_b;
    cells_t           data_b;
    logic [GEN_B-1:0] gen_b;

    rule90_seed_loader #(.WORD_W(32), .CELLS(512), .LOAD_HOLD(1), .GEN_W(16)) dut_a (
        .clk(clk), .reset(reset), .s(ifa), .load(load_a), .data(data_a),
        .busy(busy_a), .err_short(err_a), .gen_count(gen_a)
    );

    rule90_seed_loader #(.WORD_W(32), .CELLS(512), .LOAD_HOLD(HOLD_B), .GEN_W(GEN_B)) dut_b (
        .clk(clk), .reset(reset), .s(ifb), .load(load_b), .data(data_b),
        .busy(busy_b), .err_short(err_b), .gen_count(gen_b)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   qa[$];
    exp_t   qb[$];
    cells_t commit_a = '0;
    cells_t commit_b = '0;

    task automatic check(input string name, input cells_t act, input cells_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_ready();
        return sel ? ifb.in_ready : ifa.in_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_word(input logic [31:0] w, input logic last, output bit ok);
        int   n;
        logic rdy;
        ok = 1'b0;
        n  = 0;
        drv_valid = 1'b1;
        drv_data  = w;
        drv_last  = last;
        while (!ok && n < 50) begin
            rdy = cur_ready();
            @(posedge clk);
            if (rdy) ok = 1'b1;
            @(negedge clk);
            n++;
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready never seen in 50 cycles, expected a handshake");
        end
    endtask

    task automatic push_exp(input exp_t e);
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    // short_at < 0 means a full frame; last15 is the in_last value on word 15.
    task automatic send_frame(input cells_t seed, input int short_at, input bit last15, input bit gaps);
        bit   ok;
        int   hs;
        exp_t e;
        hs = 0;
        for (int k = 0; k < 16; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (k == short_at) begin
                e.is_err = 1'b1;
                e.dat    = sel ? commit_b : commit_a;
                push_exp(e);
                send_word(seed[k*32 +: 32], 1'b1, ok);
                break;
            end
            if (k == 15) begin
                e.is_err = 1'b0;
                e.dat    = seed;
                for (int r = 0; r < (sel ? HOLD_B : 1); r++) push_exp(e);
                if (sel) commit_b = seed;
                else     commit_a = seed;
            end
            send_word(seed[k*32 +: 32], (k == 15) ? last15 : 1'b0, ok);
            if (ok) hs++;
        end
        if (short_at < 0) begin
            check("frame_handshakes", cells_t'(hs), cells_t'(16));
            check("load_cycle_after_last_hs", cells_t'(sel ? load_b : load_a), cells_t'(1));
        end
    endtask

    task automatic mon_one(input bit which, input logic ld, input logic err, input logic rdy,
                           input logic bsy, input cells_t d, input logic [15:0] g);
        exp_t e;
        if (ld || err) begin
            if ((which ? qb.size() : qa.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dut%0d: load=%0b err_short=%0b, expected neither",
                         which, ld, err);
            end else begin
                e = which ? qb.pop_front() : qa.pop_front();
                check(which ? "b_event_is_err" : "a_event_is_err", cells_t'(err), cells_t'(e.is_err));
                check(which ? "b_event_load"   : "a_event_load",   cells_t'(ld),  cells_t'(!e.is_err));
                check(which ? "b_data"         : "a_data",         d,             e.dat);
                if (ld) begin
                    check(which ? "b_ready_in_load" : "a_ready_in_load", cells_t'(rdy), cells_t'(0));
                    check(which ? "b_busy_in_load"  : "a_busy_in_load",  cells_t'(bsy), cells_t'(1));
                    check(which ? "b_gen_in_load"   : "a_gen_in_load",   cells_t'(g),   cells_t'(0));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_one(1'b0, load_a, err_a, ifa.in_ready, busy_a, data_a, gen_a);
            mon_one(1'b1, load_b, err_b, ifb.in_ready, busy_b, data_b, {{(16-GEN_B){1'b0}}, gen_b});
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100000 ns, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        cells_t s;
        bit     ok;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready_a", cells_t'(ifa.in_ready), cells_t'(0));
        check("rst_in_ready_b", cells_t'(ifb.in_ready), cells_t'(0));
        check("rst_load_a",     cells_t'(load_a),       cells_t'(0));
        check("rst_busy_a",     cells_t'(busy_a),       cells_t'(0));
        check("rst_err_a",      cells_t'(err_a),        cells_t'(0));
        check("rst_data_a",     data_a,                 cells_t'(0));
        check("rst_gen_a",      cells_t'(gen_a),        cells_t'(0));
        check("rst_gen_b",      cells_t'(gen_b),        cells_t'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single seed, bit 0 only; last on word 15.
        s = '0;
        s[0] = 1'b1;
        send_frame(s, -1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("gen_after_load_a", cells_t'(gen_a), cells_t'(i));
        end

        // Random valid gaps; in_last low on word 15 must still commit.
        s = '0;
        for (int k = 0; k < 16; k++) s[k*32 +: 32] = {8'(k), 8'hA5, 8'(255 - k), 8'h3C};
        send_frame(s, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Short frame ending on word 5, then a clean full frame.
        s = '0;
        for (int k = 0; k < 16; k++) s[k*32 +: 32] = 32'h5555_0000 | 32'(k);
        send_frame(s, 5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("data_kept_after_short", data_a, commit_a);
        check("no_load_after_short", cells_t'(load_a), cells_t'(0));
        s = '0;
        for (int k = 0; k < 16; k++) s[k*32 +: 32] = {16'hBEEF, 16'(k)};
        send_frame(s, -1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset after word 9 of a frame.
        for (int k = 0; k < 10; k++) send_word(32'hFFFF_FFFF, 1'b0, ok);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data_a",  data_a,                 cells_t'(0));
        check("midrst_load_a",  cells_t'(load_a),       cells_t'(0));
        check("midrst_gen_a",   cells_t'(gen_a),        cells_t'(0));
        check("midrst_ready_a", cells_t'(ifa.in_ready), cells_t'(0));
        reset = 1'b0;
        commit_a = '0;
        commit_b = '0;
        @(negedge clk);
        s = '0;
        s[12*32 +: 32] = 32'hCAFE_F00D;
        send_frame(s, -1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // LOAD_HOLD=3 instance, seed bit 256, then saturation at 15.
        sel = 1'b1;
        @(negedge clk);
        s = '0;
        s[256] = 1'b1;
        send_frame(s, -1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("b_gen_after_load", cells_t'(gen_b), cells_t'(0));
        check("b_load_dropped",   cells_t'(load_b), cells_t'(0));
        repeat (14) @(negedge clk);
        check("b_gen_14", cells_t'(gen_b), cells_t'(14));
        @(negedge clk);
        check("b_gen_15", cells_t'(gen_b), cells_t'(15));
        repeat (10) @(negedge clk);
        check("b_gen_saturated", cells_t'(gen_b), cells_t'(15));
        check("b_data_held", data_b, s);

        check("queue_a_drained", cells_t'(qa.size()), cells_t'(0));
        check("queue_b_drained", cells_t'(qb.size()), cells_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
